// File: rtl/divider_iterative_if.sv
// Request/result bundle for divider_iterative: request handshake, abort, result handshake.
interface divider_iterative_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             out_dbz;

  modport master (
    output in_valid, in_signed, in_dividend, in_divisor, abort, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_dbz
  );

  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor, abort, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_dbz
  );
endinterface

// File: rtl/divider_iterative.sv
// Iterative restoring divider (signed/unsigned), RADIX_BITS quotient bits per cycle.
// Define DIVIDER_EARLY_EXIT_EN to finish at accept when |dividend| < |divisor|.
module divider_iterative #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input logic                clk,
  input logic                reset,
  divider_iterative_if.slave bus
);
  localparam int unsigned STEPS = WIDTH / RADIX_BITS;
  localparam int unsigned CNT_W = $clog2(STEPS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd_orig;
  logic             q_neg;
  logic             r_neg;
  logic             zero_div;

  logic             dvd_neg_c;
  logic             dvs_neg_c;
  logic [WIDTH-1:0] dvd_mag_c;
  logic [WIDTH-1:0] dvs_mag_c;
  logic [WIDTH-1:0] acc_c;
  logic [WIDTH-1:0] quo_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH-1:0] q_res_c;
  logic [WIDTH-1:0] r_res_c;

  // Operand magnitudes and sign flags at the request port
  always_comb begin
    dvd_neg_c = bus.in_signed & bus.in_dividend[WIDTH-1];
    dvs_neg_c = bus.in_signed & bus.in_divisor[WIDTH-1];
    dvd_mag_c = dvd_neg_c ? (~bus.in_dividend + WIDTH'(1)) : bus.in_dividend;
    dvs_mag_c = dvs_neg_c ? (~bus.in_divisor + WIDTH'(1)) : bus.in_divisor;
  end

  // RADIX_BITS restoring steps; acc stays below dvs between steps so WIDTH bits suffice
  always_comb begin
    acc_c   = acc;
    quo_c   = quo;
    trial_c = '0;
    for (int i = 0; i < int'(RADIX_BITS); i++) begin
      trial_c = {acc_c, quo_c[WIDTH-1]} - {1'b0, dvs};
      if (trial_c[WIDTH]) acc_c = {acc_c[WIDTH-2:0], quo_c[WIDTH-1]};
      else                acc_c = trial_c[WIDTH-1:0];
      quo_c = {quo_c[WIDTH-2:0], ~trial_c[WIDTH]};
    end
  end

  // Sign fixup of the final magnitudes; MIN/-1 wraps naturally to MIN with remainder 0
  always_comb begin
    q_res_c = q_neg ? (~quo_c + WIDTH'(1)) : quo_c;
    r_res_c = r_neg ? (~acc_c + WIDTH'(1)) : acc_c;
    if (zero_div) begin
      q_res_c = '1;
      r_res_c = dvd_orig;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      valid     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      quo       <= '0;
      dvs       <= '0;
      dvd_orig  <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      zero_div  <= 1'b0;
    end else if (bus.abort) begin
      state <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc      <= '0;
            quo      <= dvd_mag_c;
            dvs      <= dvs_mag_c;
            dvd_orig <= bus.in_dividend;
            q_neg    <= dvd_neg_c ^ dvs_neg_c;
            r_neg    <= dvd_neg_c;
            zero_div <= (bus.in_divisor == '0);
            cnt      <= '0;
            ready    <= 1'b0;
`ifdef DIVIDER_EARLY_EXIT_EN
            if ((bus.in_divisor != '0) && (dvd_mag_c < dvs_mag_c)) begin
              state     <= DONE;
              valid     <= 1'b1;
              quotient  <= '0;
              remainder <= bus.in_dividend;
              dbz       <= 1'b0;
            end else
`endif
            begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= acc_c;
          quo <= quo_c;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(STEPS - 1)) begin
            state     <= DONE;
            valid     <= 1'b1;
            quotient  <= q_res_c;
            remainder <= r_res_c;
            dbz       <= zero_div;
            cnt       <= '0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
            ready <= 1'b1;
            valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = ready;
  assign bus.out_valid     = valid;
  assign bus.out_quotient  = quotient;
  assign bus.out_remainder = remainder;
  assign bus.out_dbz       = dbz;
endmodule
